// File: rtl/player_array.sv
// N-player Pong paddle controller: synchronised buttons, per-frame position update with
// speed ramp, wall clamping, optional ball-tracking AI, and a serve recenter.
module player_array #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PADDLE_H    = 80,
    parameter int unsigned SPEED_MAX   = 8,
    parameter int unsigned AI_SPEED    = 4,
    parameter int unsigned AI_DEADBAND = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       pause,
    input  logic                       recenter,
    input  logic [NUM_PLAYERS-1:0]     ai_en,
    input  logic [NUM_PLAYERS-1:0]     btn_up,
    input  logic [NUM_PLAYERS-1:0]     btn_down,
    input  logic [Y_W-1:0]             ball_y,
    output logic [NUM_PLAYERS*Y_W-1:0] paddle_y,
    output logic [NUM_PLAYERS-1:0]     paddle_moving
);

    localparam int unsigned Y_MAX    = SCREEN_H - PADDLE_H;
    localparam int unsigned Y_CENTER = Y_MAX / 2;
    localparam int unsigned HALF_H   = PADDLE_H / 2;
    localparam int unsigned V_W      = $clog2(SPEED_MAX + 1);
    // Two spare bits so ball_y + deadband and y + step never wrap.
    localparam int unsigned A_W      = Y_W + 2;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    logic [NUM_PLAYERS-1:0] up_meta;
    logic [NUM_PLAYERS-1:0] up_sync;
    logic [NUM_PLAYERS-1:0] dn_meta;
    logic [NUM_PLAYERS-1:0] dn_sync;

    // Two-flop synchronisers for the raw buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_meta <= '0;
            up_sync <= '0;
            dn_meta <= '0;
            dn_sync <= '0;
        end else begin
            up_meta <= btn_up;
            up_sync <= up_meta;
            dn_meta <= btn_down;
            dn_sync <= dn_meta;
        end
    end

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        logic [Y_W-1:0] y_q;
        logic [Y_W-1:0] y_d;
        logic [V_W-1:0] vel_q;
        logic [V_W-1:0] vel_d;
        logic [V_W-1:0] vel_c;
        dir_t           dir_q;
        dir_t           dir_d;
        dir_t           dir_c;
        logic           mov_q;
        logic           mov_d;
        logic [A_W-1:0] cur;
        logic [A_W-1:0] ctr;
        logic [A_W-1:0] ball;
        logic [A_W-1:0] step;
        logic [A_W-1:0] up_pos;
        logic [A_W-1:0] dn_pos;
        logic [A_W-1:0] nxt;

        // Direction, velocity and clamped candidate position for a tick.
        always_comb begin
            cur    = A_W'(y_q);
            ball   = A_W'(ball_y);
            ctr    = cur + A_W'(HALF_H);
            dir_c  = DIR_HOLD;
            vel_c  = '0;
            step   = '0;
            up_pos = '0;
            dn_pos = '0;
            nxt    = cur;

            if (ai_en[i]) begin
                step = A_W'(AI_SPEED);
                if (ball + A_W'(AI_DEADBAND) < ctr) begin
                    dir_c = DIR_UP;
                end else if (ball > ctr + A_W'(AI_DEADBAND)) begin
                    dir_c = DIR_DOWN;
                end
            end else begin
                if (up_sync[i] && !dn_sync[i]) begin
                    dir_c = DIR_UP;
                end else if (dn_sync[i] && !up_sync[i]) begin
                    dir_c = DIR_DOWN;
                end
                // Ramp only when continuing a manual move; reversals restart at 1.
                if (dir_c != DIR_HOLD) begin
                    if (dir_c == dir_q && vel_q != '0) begin
                        vel_c = (vel_q >= V_W'(SPEED_MAX)) ? V_W'(SPEED_MAX) : vel_q + V_W'(1);
                    end else begin
                        vel_c = V_W'(1);
                    end
                end
                step = A_W'(vel_c);
            end

            up_pos = (cur >= step) ? cur - step : '0;
            dn_pos = (cur + step <= A_W'(Y_MAX)) ? cur + step : A_W'(Y_MAX);

            case (dir_c)
                DIR_UP:   nxt = up_pos;
                DIR_DOWN: nxt = dn_pos;
                default:  nxt = cur;
            endcase
        end

        // recenter outranks an unpaused tick; otherwise everything holds.
        always_comb begin
            y_d   = y_q;
            vel_d = vel_q;
            dir_d = dir_q;
            mov_d = mov_q;
            if (recenter) begin
                y_d   = Y_W'(Y_CENTER);
                vel_d = '0;
                dir_d = DIR_HOLD;
                mov_d = 1'b0;
            end else if (frame_tick && !pause) begin
                y_d   = Y_W'(nxt);
                vel_d = vel_c;
                dir_d = dir_c;
                mov_d = (nxt != cur);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                y_q   <= Y_W'(Y_CENTER);
                vel_q <= '0;
                dir_q <= DIR_HOLD;
                mov_q <= 1'b0;
            end else begin
                y_q   <= y_d;
                vel_q <= vel_d;
                dir_q <= dir_d;
                mov_q <= mov_d;
            end
        end

        assign paddle_y[i*Y_W +: Y_W] = y_q;
        assign paddle_moving[i]       = mov_q;
    end

endmodule

// File: tb/tb_player_array.sv
// Randomised and directed bench for player_array against a behavioural paddle model.
module tb_player_array;

    localparam int NP    = 2;
    localparam int YW    = 10;
    localparam int YMAX  = 400;
    localparam int YCTR  = 200;
    localparam int VMAX  = 8;
    localparam int AISPD = 4;
    localparam int DB    = 8;
    localparam int HALF  = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_tick;
    logic              pause;
    logic              recenter;
    logic [NP-1:0]     ai_en;
    logic [NP-1:0]     btn_up;
    logic [NP-1:0]     btn_down;
    logic [YW-1:0]     ball_y;
    logic [NP*YW-1:0]  paddle_y;
    logic [NP-1:0]     paddle_moving;

    int total = 0;
    int bad   = 0;

    // Model state: direction is -1 up, +1 down, 0 at rest.
    int m_y[NP];
    int m_vel[NP];
    int m_dir[NP];
    bit m_mov[NP];

    player_array dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .pause        (pause),
        .recenter     (recenter),
        .ai_en        (ai_en),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .ball_y       (ball_y),
        .paddle_y     (paddle_y),
        .paddle_moving(paddle_moving)
    );

    always #5 clk = ~clk;

    function automatic int get_y(input int p);
        return int'(paddle_y[p*YW +: YW]);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_y[p] = YCTR; m_vel[p] = 0; m_dir[p] = 0; m_mov[p] = 0;
        end
    endtask

    task automatic model_update(input bit ft, input bit ps, input bit rc);
        int dir;
        int spd;
        int ny;
        for (int p = 0; p < NP; p++) begin
            if (rc) begin
                m_y[p] = YCTR; m_vel[p] = 0; m_dir[p] = 0; m_mov[p] = 0;
            end else if (ft && !ps) begin
                if (ai_en[p]) begin
                    dir = 0;
                    if (int'(ball_y) + DB < m_y[p] + HALF) dir = -1;
                    else if (int'(ball_y) > m_y[p] + HALF + DB) dir = 1;
                    spd = AISPD;
                    m_vel[p] = 0;
                    m_dir[p] = 0;
                end else begin
                    dir = (btn_up[p] && !btn_down[p]) ? -1 : (btn_down[p] && !btn_up[p]) ? 1 : 0;
                    if (dir == 0) m_vel[p] = 0;
                    else if (dir == m_dir[p]) m_vel[p] = (m_vel[p] + 1 > VMAX) ? VMAX : m_vel[p] + 1;
                    else m_vel[p] = 1;
                    m_dir[p] = dir;
                    spd = m_vel[p];
                end
                ny = m_y[p] + dir * spd;
                if (ny < 0) ny = 0;
                if (ny > YMAX) ny = YMAX;
                m_mov[p] = (ny != m_y[p]);
                m_y[p] = ny;
            end
        end
    endtask

    task automatic cycle(input bit ft, input bit ps, input bit rc);
        frame_tick = ft; pause = ps; recenter = rc;
        @(posedge clk);
        model_update(ft, ps, rc);
        #1;
        frame_tick = 1'b0; recenter = 1'b0;
    endtask

    // New button levels, then enough idle clocks for them to clear the synchronisers.
    task automatic set_buttons(input logic [NP-1:0] up, input logic [NP-1:0] dn);
        btn_up = up; btn_down = dn;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_tick = 0; pause = 0; recenter = 0;
        ai_en = '0; btn_up = '0; btn_down = '0; ball_y = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int p = 0; p < NP; p++) begin
            total++;
            if (get_y(p) !== YCTR || paddle_moving[p] !== 1'b0) begin
                bad++; $display("FAIL reset p%0d: y=%0d mov=%b want y=%0d mov=0", p, get_y(p), paddle_moving[p], YCTR);
            end
        end
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        for (int p = 0; p < NP; p++) begin
            total++;
            if (get_y(p) !== YCTR || paddle_moving[p] !== 1'b0) begin
                bad++; $display("FAIL idle_ticks p%0d: y=%0d mov=%b want y=%0d mov=0", p, get_y(p), paddle_moving[p], YCTR);
            end
        end
    endtask

    task automatic test_manual_up();
        int exp_y[12];
        exp_y = '{199, 197, 194, 190, 185, 179, 172, 164, 156, 148, 140, 132};
        set_buttons(2'b01, 2'b00);
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            total++;
            if (get_y(0) !== exp_y[k] || paddle_moving[0] !== 1'b1 || get_y(1) !== YCTR) begin
                bad++; $display("FAIL ramp_up tick%0d: y0=%0d mov0=%b y1=%0d want y0=%0d mov0=1 y1=%0d",
                                k, get_y(0), paddle_moving[0], get_y(1), exp_y[k], YCTR);
            end
        end
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            total++;
            if (get_y(0) !== m_y[0] || paddle_moving[0] !== m_mov[0]) begin
                bad++; $display("FAIL to_top tick%0d: y0=%0d mov0=%b want y0=%0d mov0=%b",
                                k, get_y(0), paddle_moving[0], m_y[0], m_mov[0]);
            end
        end
        total++;
        if (get_y(0) !== 0 || paddle_moving[0] !== 1'b0) begin
            bad++; $display("FAIL pinned_top: y0=%0d mov0=%b want y0=0 mov0=0", get_y(0), paddle_moving[0]);
        end
    endtask

    task automatic test_down_both();
        int exp_y[3];
        exp_y = '{399, 397, 398};
        cycle(1'b0, 1'b0, 1'b1);
        set_buttons(2'b00, 2'b10);
        repeat (40) cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== YMAX || paddle_moving[1] !== 1'b0) begin
            bad++; $display("FAIL pinned_bottom: y1=%0d mov1=%b want y1=%0d mov1=0", get_y(1), paddle_moving[1], YMAX);
        end
        set_buttons(2'b10, 2'b10);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== YMAX || paddle_moving[1] !== 1'b0) begin
            bad++; $display("FAIL both_pressed: y1=%0d mov1=%b want y1=%0d mov1=0", get_y(1), paddle_moving[1], YMAX);
        end
        set_buttons(2'b10, 2'b00);
        cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== exp_y[0]) begin
            bad++; $display("FAIL restart_step1: y1=%0d want %0d", get_y(1), exp_y[0]);
        end
        cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== exp_y[1]) begin
            bad++; $display("FAIL restart_step2: y1=%0d want %0d", get_y(1), exp_y[1]);
        end
        set_buttons(2'b00, 2'b10);
        cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== exp_y[2] || get_y(1) !== m_y[1]) begin
            bad++; $display("FAIL reversal: y1=%0d want %0d", get_y(1), exp_y[2]);
        end
    endtask

    task automatic test_recenter_pause();
        cycle(1'b0, 1'b0, 1'b1);
        set_buttons(2'b01, 2'b00);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        total++;
        if (get_y(0) !== 185 || paddle_moving[0] !== 1'b1) begin
            bad++; $display("FAIL paused_hold: y0=%0d mov0=%b want y0=185 mov0=1", get_y(0), paddle_moving[0]);
        end
        cycle(1'b1, 1'b1, 1'b1);
        for (int p = 0; p < NP; p++) begin
            total++;
            if (get_y(p) !== YCTR || paddle_moving[p] !== 1'b0) begin
                bad++; $display("FAIL recenter p%0d: y=%0d mov=%b want y=%0d mov=0", p, get_y(p), paddle_moving[p], YCTR);
            end
        end
        cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(0) !== 199) begin
            bad++; $display("FAIL post_recenter_step: y0=%0d want 199", get_y(0));
        end
        pause = 1'b0;
    endtask

    task automatic test_ai();
        cycle(1'b0, 1'b0, 1'b1);
        set_buttons(2'b01, 2'b10);
        ai_en = 2'b01;
        ball_y = 10'd50;
        for (int k = 0; k < 60; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            total++;
            if (get_y(0) !== m_y[0] || paddle_moving[0] !== m_mov[0]) begin
                bad++; $display("FAIL ai tick%0d: y0=%0d mov0=%b want y0=%0d mov0=%b",
                                k, get_y(0), paddle_moving[0], m_y[0], m_mov[0]);
            end
        end
        total++;
        if (get_y(0) !== 16 || paddle_moving[0] !== 1'b0) begin
            bad++; $display("FAIL ai_settle: y0=%0d mov0=%b want y0=16 mov0=0", get_y(0), paddle_moving[0]);
        end
        ai_en = '0;
    endtask

    task automatic test_reset_midramp();
        cycle(1'b0, 1'b0, 1'b1);
        set_buttons(2'b00, 2'b10);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== 215) begin
            bad++; $display("FAIL ramp5: y1=%0d want 215", get_y(1));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (get_y(1) !== YCTR || paddle_moving[1] !== 1'b0) begin
            bad++; $display("FAIL async_reset: y1=%0d mov1=%b want y1=%0d mov1=0", get_y(1), paddle_moving[1], YCTR);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (get_y(1) !== 201) begin
            bad++; $display("FAIL reset_restart: y1=%0d want 201", get_y(1));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            ai_en  = NP'($urandom_range(3, 0) == 0 ? $urandom : 0);
            ball_y = YW'($urandom_range(479, 0));
            set_buttons(NP'($urandom), NP'($urandom));
            cycle(1'b1, ($urandom_range(9, 0) == 0), ($urandom_range(19, 0) == 0));
            for (int p = 0; p < NP; p++) begin
                total++;
                if (get_y(p) !== m_y[p] || paddle_moving[p] !== m_mov[p]) begin
                    bad++; $display("FAIL random it%0d p%0d: y=%0d mov=%b want y=%0d mov=%b",
                                    k, p, get_y(p), paddle_moving[p], m_y[p], m_mov[p]);
                end
            end
        end
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual_up();
        test_down_both();
        test_recenter_pause();
        test_ai();
        test_reset_midramp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
